md_unit_ctrl: RTL
=================

Name: md_unit_ctrl

Overview:
Sequences the multiply/divide resource and owns the architectural HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and latches the operands.
- Counts the operation latency, then commits the result to HI/LO.
- Raises a stall request to the hazard logic for any HI/LO-related instruction in E while an operation is pending.
- Its Busy count is what the pipeline registers carry forward to the W stage.

Parameters:
MULT_LAT, 5, busy cycles for mult/multu (legal 1..31)
DIV_LAT, 10, busy cycles for div/divu (legal 1..31)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
MAD_start  in  1  E-stage instruction is mult/multu/div/divu/mthi/mtlo
MAD_sel  in  3  op code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved
ifMAD  in  1  E-stage instruction touches HI/LO (includes mfhi/mflo)
exc_cancel  in  1  exception/interrupt/eret taken this cycle; suppresses the E-stage op
A  in  32  rs value (forwarded)
B  in  32  rt value (forwarded)
HI  out  32  HI register
LO  out  32  LO register
busy  out  1  operation in progress
Busy  out  5  remaining busy cycles, 0 when idle
stall_req  out  1  stall E and earlier stages

Behaviour:
- Clock and reset: single clock, clk; reset is synchronous and active-high.
- Reset: state IDLE; HI=0, LO=0, Busy=0, busy=0; operand latches cleared. Reset mid-operation aborts the operation; no result is written.
- States:
  - IDLE.
  - MUL: entered with Busy=MULT_LAT.
  - DIV: entered with Busy=DIV_LAT.
- Accepted start: MAD_start & ~exc_cancel & state==IDLE.
- Start of mult/multu/div/divu in cycle t:
  - latch A, B and the signed/unsigned flag.
  - busy=1 from t+1; Busy counts down by 1 per cycle.
  - In the cycle Busy==1: HI/LO are written; state returns to IDLE.
  - Result is visible and busy=0 at cycle t+LAT+1.
- mthi/mtlo accepted at t: HI or LO = A, visible at t+1. No busy state; the other register is unchanged.
- Results:
  - mult/multu: {HI,LO} = 64-bit product, signed or unsigned respectively.
  - div: LO = quotient, HI = remainder, signed, truncating toward zero; remainder takes the sign of the dividend.
  - divu: same, unsigned.
- Divide by zero: still busy DIV_LAT cycles; HI/LO unchanged at completion.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- stall_req = ifMAD & (busy | accepted start of a latency op in this same cycle's predecessor), i.e. ifMAD & busy; combinational from registered busy.
- MAD_start while busy is blocked by stall_req. If it occurs anyway, it is ignored (bench asserts it never happens).
- exc_cancel in the same cycle as MAD_start: no start, no HI/LO write.
- exc_cancel while busy: the in-flight op completes normally (already committed past E).
- Reserved MAD_sel values (6-7) with MAD_start: treated as no-op.
- HI/LO read by mfhi/mflo: outputs are the current registers. No bypass of in-flight results; the stall covers the gap.

Decomposition:
- Shared package md_pkg holds:
  - MAD_sel codes (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - State encoding (MD_IDLE, MD_MUL, MD_DIV).
  - Default latency constants, which the CPU-level Busy/Tnew logic also uses.
- One sub-module, md_arith: purely combinational 64-bit product and quotient/remainder from the latched operands and signed flag, plus a div-by-zero flag. The controller owns all state, counting and commit.

Test Plan:
- mult A=0xFFFFFFFF, B=2 at t -> busy t+1..t+5; Busy 5,4,3,2,1; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy=0.
- multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. mflo (ifMAD=1) presented at t+3 -> stall_req=1 until t+10, 0 at t+11.
- mthi then divu A=7, B=0:
  - mthi A=0x1234 -> HI=0x1234 next cycle, LO unchanged, busy=0.
  - divu A=7, B=0 -> 10 busy cycles, HI=0x1234 and LO unchanged afterwards.
- mult with exc_cancel=1 in the start cycle -> busy stays 0, HI/LO unchanged.
- div started, exc_cancel pulsed at t+4 -> still completes at t+11 with correct result.
- reset asserted at t+3 of a div -> next cycle HI=LO=0, Busy=0, busy=0; no later write.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MAD_sel op codes
//   - controller state encoding
//   - default latencies, also used by the CPU-level Busy/Tnew logic
package md_pkg;

    // MAD_sel op codes; 6 and 7 are reserved and behave as no-ops.
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Controller states. The divide state is MD_DIVS because MD_DIV is
    // already taken by the op code.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIVS = 2'd2
    } md_state_e;

    localparam int MD_MULT_LAT = 5;
    localparam int MD_DIV_LAT  = 10;

    // True for the two signed ops; the unsigned ops share the datapath.
    function automatic logic md_op_signed(input logic [2:0] sel);
        return (sel == MD_MULT) || (sel == MD_DIV);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   a, b         latched operands (dividend/divisor for divides)
//   is_signed    treat operands as two's complement
//   product      64-bit product {hi, lo}
//   quotient     quotient, truncated toward zero
//   remainder    remainder, sign follows the dividend
//   div_by_zero  b == 0; quotient/remainder are meaningless then
module md_arith (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [63:0] product,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [63:0] a_ext;
    logic [63:0] b_ext;

    always_comb begin
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];

        // Sign-extend only in signed mode; the low 64 bits of a 64x64
        // product of extended operands are the correct result either way.
        a_ext   = {{32{a_neg}}, a};
        b_ext   = {{32{b_neg}}, b};
        product = a_ext * b_ext;

        // Divide on magnitudes and reapply signs. This also yields the
        // architected 0x80000000 / -1 result (quotient 0x80000000, rem 0)
        // without relying on signed-division overflow behaviour.
        a_mag       = a_neg ? (~a + 32'd1) : a;
        b_mag       = b_neg ? (~b + 32'd1) : b;
        div_by_zero = (b == 32'd0);
        b_div       = div_by_zero ? 32'd1 : b_mag;
        q_mag       = a_mag / b_div;
        r_mag       = a_mag % b_div;
        quotient    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        remainder   = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer and owner of the architectural HI/LO registers.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   MAD_start    E-stage op is mult/multu/div/divu/mthi/mtlo
//   MAD_sel      op code (see md_pkg)
//   ifMAD        E-stage instruction touches HI/LO
//   exc_cancel   exception taken this cycle; suppresses the E-stage op
//   A, B         forwarded rs/rt values
//   HI, LO       architectural registers
//   busy, Busy   operation in flight / remaining busy cycles
//   stall_req    stall E and earlier stages
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT,
    parameter int DIV_LAT  = MD_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MAD_start,
    input  logic [2:0]  MAD_sel,
    input  logic        ifMAD,
    input  logic        exc_cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic [4:0]  Busy,
    output logic        stall_req
);

    md_state_e   state_reg,  state_next;
    logic [4:0]  cnt_reg,    cnt_next;
    logic [31:0] a_reg,      a_next;
    logic [31:0] b_reg,      b_next;
    logic        signed_reg, signed_next;
    logic [31:0] hi_reg,     hi_next;
    logic [31:0] lo_reg,     lo_next;

    logic        start_ok;
    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    md_arith u_arith (
        .a           (a_reg),
        .b           (b_reg),
        .is_signed   (signed_reg),
        .product     (product),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= MD_IDLE;
            cnt_reg    <= 5'd0;
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            signed_reg <= 1'b0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            signed_reg <= signed_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        signed_next = signed_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;

        // A start while busy is simply ignored; the stall should prevent it.
        start_ok = MAD_start & ~exc_cancel & (state_reg == MD_IDLE);

        case (state_reg)
            MD_IDLE: begin
                if (start_ok) begin
                    case (MAD_sel)
                        MD_MULT, MD_MULTU: begin
                            state_next  = MD_MUL;
                            cnt_next    = 5'(MULT_LAT);
                            a_next      = A;
                            b_next      = B;
                            signed_next = md_op_signed(MAD_sel);
                        end
                        MD_DIV, MD_DIVU: begin
                            state_next  = MD_DIVS;
                            cnt_next    = 5'(DIV_LAT);
                            a_next      = A;
                            b_next      = B;
                            signed_next = md_op_signed(MAD_sel);
                        end
                        MD_MTHI: hi_next = A;
                        MD_MTLO: lo_next = A;
                        default: ;
                    endcase
                end
            end
            MD_MUL: begin
                if (cnt_reg == 5'd1) begin
                    {hi_next, lo_next} = product;
                    state_next         = MD_IDLE;
                    cnt_next           = 5'd0;
                end else begin
                    cnt_next = cnt_reg - 5'd1;
                end
            end
            MD_DIVS: begin
                if (cnt_reg == 5'd1) begin
                    // Divide by zero still burns the full latency but
                    // leaves HI/LO untouched.
                    if (!div_by_zero) begin
                        hi_next = remainder;
                        lo_next = quotient;
                    end
                    state_next = MD_IDLE;
                    cnt_next   = 5'd0;
                end else begin
                    cnt_next = cnt_reg - 5'd1;
                end
            end
            default: begin
                state_next = MD_IDLE;
                cnt_next   = 5'd0;
            end
        endcase
    end

    assign HI        = hi_reg;
    assign LO        = lo_reg;
    assign busy      = (state_reg != MD_IDLE);
    assign Busy      = cnt_reg;
    assign stall_req = ifMAD & busy;

endmodule
